// File: rtl/game_pkg.sv
// Shared definitions for the game sprite blocks: default screen/sprite
// dimensions and the motion controller state encoding.
package game_pkg;

  localparam int SCREEN_W_DEF = 640;
  localparam int SCREEN_H_DEF = 480;
  localparam int SPRITE_W_DEF = 8;
  localparam int SPRITE_H_DEF = 8;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } motion_state_t;

endpackage

// File: rtl/game_sprite_axis.sv
// One-axis position step with edge handling (bounce or wrap).
// Bounce behaviour is selected by defining GAME_SPRITE_BOUNCE_EN; wrap otherwise.
module game_sprite_axis #(
  parameter int POS_W = 10,
  parameter int VEL_W = 4,
  parameter int MAX   = 632
) (
  input  logic [POS_W-1:0] pos,
  input  logic [VEL_W-1:0] vel,
  output logic [POS_W-1:0] pos_next,
  output logic [VEL_W-1:0] vel_next,
  output logic             edge_hit
);

  localparam int S = POS_W + 2;
  localparam logic signed [S-1:0] MAX_S  = S'(MAX);
  localparam logic signed [S-1:0] SPAN_S = S'(MAX + 1);

  logic signed [S-1:0] w_vel_ext;
  logic signed [S-1:0] w_sum;
  logic signed [S-1:0] w_wrap;
  logic                w_low;
  logic                w_high;

`ifdef GAME_SPRITE_BOUNCE_EN
  // The most-negative velocity has no positive twin, so it saturates.
  function automatic logic [VEL_W-1:0] sat_neg(input logic [VEL_W-1:0] v);
    logic [VEL_W-1:0] most_neg;
    most_neg = {1'b1, {(VEL_W-1){1'b0}}};
    if (v == most_neg) sat_neg = {1'b0, {(VEL_W-1){1'b1}}};
    else               sat_neg = ~v + {{(VEL_W-1){1'b0}}, 1'b1};
  endfunction
`endif

  always_comb begin
    w_vel_ext = $signed({{(S-VEL_W){vel[VEL_W-1]}}, vel});
    w_sum     = $signed({2'b00, pos}) + w_vel_ext;
    w_low     = w_sum[S-1];
    w_high    = !w_low && (w_sum > MAX_S);
    edge_hit  = w_low || w_high || (w_sum == '0) || (w_sum == MAX_S);
    w_wrap    = w_sum;
`ifdef GAME_SPRITE_BOUNCE_EN
    if (w_low) begin
      pos_next = '0;
      vel_next = sat_neg(vel);
    end else if (w_high) begin
      pos_next = MAX_S[POS_W-1:0];
      vel_next = sat_neg(vel);
    end else begin
      pos_next = w_sum[POS_W-1:0];
      vel_next = vel;
    end
`else
    if (w_low)       w_wrap = w_sum + SPAN_S;
    else if (w_high) w_wrap = w_sum - SPAN_S;
    else             w_wrap = w_sum;
    pos_next = w_wrap[POS_W-1:0];
    vel_next = vel;
`endif
  end

endmodule

// File: rtl/game_sprite_motion.sv
// Sprite motion controller: strobe-driven X/Y stepping with load priority.
// Edge behaviour: GAME_SPRITE_BOUNCE_EN defined = bounce, undefined = wrap.
module game_sprite_motion
  import game_pkg::*;
#(
  parameter int x_width       = 10,
  parameter int y_width       = 10,
  parameter int dx_width      = 4,
  parameter int dy_width      = 4,
  parameter int screen_width  = SCREEN_W_DEF,
  parameter int screen_height = SCREEN_H_DEF,
  parameter int sprite_width  = SPRITE_W_DEF,
  parameter int sprite_height = SPRITE_H_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                strobe,
  input  logic                run,
  input  logic                load_xy,
  input  logic                load_dxy,
  input  logic [x_width-1:0]  x_in,
  input  logic [y_width-1:0]  y_in,
  input  logic [dx_width-1:0] dx_in,
  input  logic [dy_width-1:0] dy_in,
  output logic [x_width-1:0]  x,
  output logic [y_width-1:0]  y,
  output logic [dx_width-1:0] dx,
  output logic [dy_width-1:0] dy,
  output logic                moving,
  output logic                edge_hit
);

  localparam int XMAX = screen_width - sprite_width;
  localparam int YMAX = screen_height - sprite_height;
  localparam logic [x_width-1:0] XMAX_V = x_width'(XMAX);
  localparam logic [y_width-1:0] YMAX_V = y_width'(YMAX);

  motion_state_t r_state, w_state_next;
  logic [x_width-1:0]  r_x;
  logic [y_width-1:0]  r_y;
  logic [dx_width-1:0] r_dx;
  logic [dy_width-1:0] r_dy;
  logic                r_edge_hit;

  logic [x_width-1:0]  w_x_next, w_x_ld;
  logic [y_width-1:0]  w_y_next, w_y_ld;
  logic [dx_width-1:0] w_dx_next;
  logic [dy_width-1:0] w_dy_next;
  logic                w_edge_x, w_edge_y;
  logic                w_update;

  game_sprite_axis #(.POS_W(x_width), .VEL_W(dx_width), .MAX(XMAX)) u_axis_x (
    .pos(r_x), .vel(r_dx), .pos_next(w_x_next), .vel_next(w_dx_next), .edge_hit(w_edge_x)
  );

  game_sprite_axis #(.POS_W(y_width), .VEL_W(dy_width), .MAX(YMAX)) u_axis_y (
    .pos(r_y), .vel(r_dy), .pos_next(w_y_next), .vel_next(w_dy_next), .edge_hit(w_edge_y)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (run)  w_state_next = RUN;
      RUN:     if (!run) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_comb begin
    moving   = (r_state == RUN);
    w_update = (r_state == RUN) && strobe && !load_xy;
    w_x_ld   = (x_in > XMAX_V) ? XMAX_V : x_in;
    w_y_ld   = (y_in > YMAX_V) ? YMAX_V : y_in;
  end

  // Position load beats motion; velocity load beats bounce negation.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_x        <= '0;
      r_y        <= '0;
      r_dx       <= '0;
      r_dy       <= '0;
      r_edge_hit <= 1'b0;
    end else begin
      r_edge_hit <= w_update && (w_edge_x || w_edge_y);
      if (load_xy) begin
        r_x <= w_x_ld;
        r_y <= w_y_ld;
      end else if (w_update) begin
        r_x <= w_x_next;
        r_y <= w_y_next;
      end
      if (load_dxy) begin
        r_dx <= dx_in;
        r_dy <= dy_in;
      end else if (w_update) begin
        r_dx <= w_dx_next;
        r_dy <= w_dy_next;
      end
    end
  end

  assign x        = r_x;
  assign y        = r_y;
  assign dx       = r_dx;
  assign dy       = r_dy;
  assign edge_hit = r_edge_hit;

endmodule

// File: tb/tb_game_sprite_motion.sv
// Directed bench for game_sprite_motion; expectations follow the build's
// edge mode (GAME_SPRITE_BOUNCE_EN defined = bounce, otherwise wrap).
module tb_game_sprite_motion;

  logic       clk = 1'b0;
  logic       reset;
  logic       strobe, run, load_xy, load_dxy;
  logic [9:0] x_in, y_in;
  logic [3:0] dx_in, dy_in;
  logic [9:0] x, y;
  logic [3:0] dx, dy;
  logic       moving, edge_hit;

  int checks = 0;
  int failures = 0;

  game_sprite_motion dut (
    .clk(clk), .reset(reset), .strobe(strobe), .run(run),
    .load_xy(load_xy), .load_dxy(load_dxy),
    .x_in(x_in), .y_in(y_in), .dx_in(dx_in), .dy_in(dy_in),
    .x(x), .y(y), .dx(dx), .dy(dy), .moving(moving), .edge_hit(edge_hit)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [9:0] lx, input logic [9:0] ly,
                      input logic [3:0] ldx, input logic [3:0] ldy);
    x_in = lx; y_in = ly; dx_in = ldx; dy_in = ldy;
    load_xy = 1'b1; load_dxy = 1'b1;
    step();
    load_xy = 1'b0; load_dxy = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; strobe = 1'b0; run = 1'b0; load_xy = 1'b0; load_dxy = 1'b0;
    x_in = 10'd0; y_in = 10'd0; dx_in = 4'd0; dy_in = 4'd0;
    step(); step();
    checks++;
    if ({x, y, dx, dy, moving, edge_hit} !== {10'd0, 10'd0, 4'd0, 4'd0, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL reset_state got x=%0d y=%0d dx=%0d dy=%0d mv=%b eh=%b want all 0", x, y, dx, dy, moving, edge_hit);
    end
    reset = 1'b0;
    step();
  endtask

  task automatic test_basic_motion();
    load(10'd100, 10'd200, 4'd3, 4'b1110);
    checks++;
    if ({x, y, dx, dy} !== {10'd100, 10'd200, 4'd3, 4'b1110}) begin
      failures++;
      $display("FAIL load got (%0d,%0d,%h,%h) want (100,200,3,e)", x, y, dx, dy);
    end
    run = 1'b1;
    step();
    checks++;
    if (moving !== 1'b1) begin
      failures++;
      $display("FAIL moving_run got %b want 1", moving);
    end
    strobe = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      step();
      checks++;
      if ({x, y, edge_hit} !== {10'(100 + 3*i), 10'(200 - 2*i), 1'b0}) begin
        failures++;
        $display("FAIL back_to_back_%0d got (%0d,%0d) eh=%b want (%0d,%0d) eh=0", i, x, y, edge_hit, 100 + 3*i, 200 - 2*i);
      end
    end
    strobe = 1'b0;
  endtask

  task automatic test_edges();
    load(10'd630, 10'd1, 4'd5, 4'b1000);
    strobe = 1'b1;
    step();
    strobe = 1'b0;
    checks++;
`ifdef GAME_SPRITE_BOUNCE_EN
    if ({x, dx, y, dy, edge_hit} !== {10'd632, 4'b1011, 10'd0, 4'b0111, 1'b1}) begin
      failures++;
      $display("FAIL bounce got x=%0d dx=%h y=%0d dy=%h eh=%b want 632 b 0 7 1", x, dx, y, dy, edge_hit);
    end
`else
    if ({x, dx, y, dy, edge_hit} !== {10'd2, 4'd5, 10'd466, 4'b1000, 1'b1}) begin
      failures++;
      $display("FAIL wrap_hi got x=%0d dx=%h y=%0d dy=%h eh=%b want 2 5 466 8 1", x, dx, y, dy, edge_hit);
    end
`endif
    step();
    checks++;
    if (edge_hit !== 1'b0) begin
      failures++;
      $display("FAIL edge_pulse_width got %b want 0", edge_hit);
    end
    load(10'd1, 10'd100, 4'b1101, 4'd0);
    strobe = 1'b1;
    step();
    strobe = 1'b0;
    checks++;
`ifdef GAME_SPRITE_BOUNCE_EN
    if ({x, dx, y, edge_hit} !== {10'd0, 4'd3, 10'd100, 1'b1}) begin
      failures++;
      $display("FAIL bounce_lo got x=%0d dx=%h y=%0d eh=%b want 0 3 100 1", x, dx, y, edge_hit);
    end
`else
    if ({x, dx, y, edge_hit} !== {10'd631, 4'b1101, 10'd100, 1'b1}) begin
      failures++;
      $display("FAIL wrap_lo got x=%0d dx=%h y=%0d eh=%b want 631 d 100 1", x, dx, y, edge_hit);
    end
`endif
    load(10'd3, 10'd100, 4'b1101, 4'd0);
    strobe = 1'b1;
    step();
    strobe = 1'b0;
    checks++;
    if ({x, dx, edge_hit} !== {10'd0, 4'b1101, 1'b1}) begin
      failures++;
      $display("FAIL land_zero got x=%0d dx=%h eh=%b want 0 d 1", x, dx, edge_hit);
    end
  endtask

  task automatic test_priority();
    load(10'd50, 10'd60, 4'd4, 4'd4);
    x_in = 10'd10; y_in = 10'd10; load_xy = 1'b1; strobe = 1'b1;
    step();
    load_xy = 1'b0; strobe = 1'b0;
    step();
    checks++;
    if ({x, y, edge_hit} !== {10'd10, 10'd10, 1'b0}) begin
      failures++;
      $display("FAIL load_beats_strobe got (%0d,%0d) eh=%b want (10,10) 0", x, y, edge_hit);
    end
    load(10'd630, 10'd10, 4'd5, 4'd1);
    dx_in = 4'd2; dy_in = 4'd3; load_dxy = 1'b1; strobe = 1'b1;
    step();
    load_dxy = 1'b0; strobe = 1'b0;
    checks++;
`ifdef GAME_SPRITE_BOUNCE_EN
    if ({x, y, dx, dy, edge_hit} !== {10'd632, 10'd11, 4'd2, 4'd3, 1'b1}) begin
`else
    if ({x, y, dx, dy, edge_hit} !== {10'd2, 10'd11, 4'd2, 4'd3, 1'b1}) begin
`endif
      failures++;
      $display("FAIL load_dxy_beats_bounce got x=%0d y=%0d dx=%h dy=%h eh=%b", x, y, dx, dy, edge_hit);
    end
    x_in = 10'd1000; y_in = 10'd500; load_xy = 1'b1;
    step();
    load_xy = 1'b0;
    checks++;
    if ({x, y} !== {10'd632, 10'd472}) begin
      failures++;
      $display("FAIL load_clamp got (%0d,%0d) want (632,472)", x, y);
    end
  endtask

  task automatic test_gating();
    load(10'd200, 10'd200, 4'd1, 4'd1);
    run = 1'b0;
    step();
    strobe = 1'b1;
    for (int i = 0; i < 5; i++) step();
    checks++;
    if ({x, y, moving, edge_hit} !== {10'd200, 10'd200, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL idle_strobes got (%0d,%0d) mv=%b want (200,200) mv=0", x, y, moving);
    end
    run = 1'b1;
    step();
    strobe = 1'b0;
    checks++;
    if ({x, y, moving} !== {10'd200, 10'd200, 1'b1}) begin
      failures++;
      $display("FAIL run_rise_strobe got (%0d,%0d) mv=%b want (200,200) mv=1", x, y, moving);
    end
    strobe = 1'b1;
    step();
    strobe = 1'b0;
    checks++;
    if ({x, y} !== {10'd201, 10'd201}) begin
      failures++;
      $display("FAIL first_motion got (%0d,%0d) want (201,201)", x, y);
    end
  endtask

  task automatic test_reset_midrun();
    load(10'd631, 10'd300, 4'd1, 4'd2);
    strobe = 1'b1;
    step();
    strobe = 1'b0;
    reset = 1'b1;
    #1;
    checks++;
    if ({x, y, dx, dy, moving, edge_hit} !== {10'd0, 10'd0, 4'd0, 4'd0, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL async_reset got x=%0d y=%0d dx=%0d dy=%0d mv=%b eh=%b want all 0", x, y, dx, dy, moving, edge_hit);
    end
    step();
    reset = 1'b0;
    step();
  endtask

  initial begin
    test_reset();
    test_basic_motion();
    test_edges();
    test_priority();
    test_gating();
    test_reset_midrun();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
